// File: rtl/fft_spectrum_server.sv
`default_nettype none
// ============================================================================
// Module   : fft_spectrum_server
// Purpose  : Turns streaming complex FFT bins into per-bin power values and
//            stores them in a ping-pong RAM. The display generator reads one
//            bank while the FFT fills the other. Banks swap only on a vsync
//            leading edge, so a video frame never mixes two FFT frames.
// Revision : 1.0 - initial release
// ============================================================================
module fft_spectrum_server #(
    parameter int FFT_POINT = 256,
    parameter int ADDR_BITS = 10,
    parameter int DATA_W    = 16,
    parameter int SHIFT     = 0,
    parameter int VS_POL    = 1
) (
    input  logic                     pix_clk,
    input  logic                     rst,
    input  logic                     fft_valid,
    input  logic                     fft_last,
    input  logic signed [DATA_W-1:0] fft_re,
    input  logic signed [DATA_W-1:0] fft_im,
    input  logic                     vs_in,
    input  logic                     data_req,
    input  logic [ADDR_BITS-1:0]     RAM_address,
    output logic [31:0]              fft_data,
    output logic                     fft_data_vld,
    output logic                     frame_ready,
    output logic [7:0]               drop_cnt,
    output logic [7:0]               err_cnt
);
    localparam int                 c_KW       = (FFT_POINT > 1) ? $clog2(FFT_POINT) : 1;
    localparam logic [c_KW-1:0]    c_LAST_BIN = c_KW'(FFT_POINT - 1);
    localparam logic [ADDR_BITS:0] c_NUM_BINS = (ADDR_BITS + 1)'(FFT_POINT);
    localparam logic               c_VS_ACT   = (VS_POL != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_SKIP = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_KW-1:0]     r_k;
    logic                r_rd_bank;
    logic                r_pending;
    logic                r_vs_act;

    logic                r_s1_vld, r_s1_last;
    logic [c_KW-1:0]     r_s1_idx;
    logic [2*DATA_W-1:0] r_re_sq, r_im_sq;
    logic                r_s2_vld, r_s2_last;
    logic [c_KW-1:0]     r_s2_idx;
    logic [31:0]         r_pwr;

    logic [31:0]         r_ram [0:2*FFT_POINT-1];
    logic [31:0]         r_rd_word;
    logic                r_rd_zero;

    logic                        w_take, w_last_ok, w_err, w_drop;
    logic                        w_vs_act, w_swap, w_addr_ok;
    logic [c_KW-1:0]             w_idx;
    logic signed [2*DATA_W-1:0]  w_re_ext, w_im_ext;
    logic [2*DATA_W:0]           w_sum;

    // Bin index of the incoming sample: 0 when a frame starts, else previous+1
    assign w_idx     = (r_state == S_FILL) ? r_k + 1'b1 : '0;
    assign w_take    = fft_valid && ((r_state == S_IDLE) || (r_state == S_FILL));
    assign w_last_ok = w_take && fft_last && (w_idx == c_LAST_BIN);
    // Malformed: last too early, or the final bin arrives without last
    assign w_err     = w_take && (fft_last ? (w_idx != c_LAST_BIN) : (w_idx == c_LAST_BIN));
    assign w_drop    = (r_state == S_WAIT) && fft_valid && fft_last;

    assign w_vs_act  = (vs_in == c_VS_ACT);
    // Registered pending only: a frame finishing on the vs edge waits a frame
    assign w_swap    = w_vs_act && !r_vs_act && r_pending;
    assign w_addr_ok = ({1'b0, RAM_address} < c_NUM_BINS);

    assign w_re_ext  = {{DATA_W{fft_re[DATA_W-1]}}, fft_re};
    assign w_im_ext  = {{DATA_W{fft_im[DATA_W-1]}}, fft_im};
    assign w_sum     = {1'b0, r_re_sq} + {1'b0, r_im_sq};

    // Power pipeline: squares, then sum and scale; RAM write on the next edge
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_idx  <= '0;
            r_re_sq   <= '0;
            r_im_sq   <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_idx  <= '0;
            r_pwr     <= '0;
        end else begin
            r_s1_vld  <= w_take;
            r_s1_last <= w_last_ok;
            r_s1_idx  <= w_idx;
            r_re_sq   <= w_re_ext * w_re_ext;
            r_im_sq   <= w_im_ext * w_im_ext;
            r_s2_vld  <= r_s1_vld;
            r_s2_last <= r_s1_last;
            r_s2_idx  <= r_s1_idx;
            r_pwr     <= 32'(w_sum >> SHIFT);
        end
    end

    // Ping-pong RAM: write into the bank not on display, registered read
    always_ff @(posedge pix_clk) begin
        if (r_s2_vld) begin
            r_ram[{~r_rd_bank, r_s2_idx}] <= r_pwr;
        end
        if (data_req) begin
            r_rd_word <= r_ram[{r_rd_bank, RAM_address[c_KW-1:0]}];
        end
    end

    // Read qualifier: out-of-range bins or no frame yet read back as zero
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            r_rd_zero    <= 1'b1;
            fft_data_vld <= 1'b0;
        end else begin
            fft_data_vld <= data_req;
            if (data_req) begin
                r_rd_zero <= !(w_addr_ok && frame_ready);
            end
        end
    end

    assign fft_data = r_rd_zero ? 32'd0 : r_rd_word;

    // Writer FSM, bank swap, pending flag and saturating status counters
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_rd_bank   <= 1'b0;
            r_pending   <= 1'b0;
            r_vs_act    <= 1'b0;
            frame_ready <= 1'b0;
            drop_cnt    <= 8'd0;
            err_cnt     <= 8'd0;
        end else begin
            r_vs_act <= w_vs_act;
            if (r_s2_vld && r_s2_last) begin
                r_pending <= 1'b1;
            end
            if (w_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (w_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (w_swap) begin
                r_rd_bank   <= ~r_rd_bank;
                r_pending   <= 1'b0;
                frame_ready <= 1'b1;
                r_state     <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_FILL: begin
                        if (fft_valid) begin
                            r_k <= w_idx;
                            if (w_last_ok) begin
                                r_state <= S_WAIT;
                            end else if (fft_last) begin
                                // Frame already closed by fft_last: nothing to skip
                                r_state <= S_IDLE;
                            end else if (w_idx == c_LAST_BIN) begin
                                r_state <= S_SKIP;
                            end else begin
                                r_state <= S_FILL;
                            end
                        end
                    end
                    S_SKIP: begin
                        if (fft_valid && fft_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_WAIT: begin
                        r_state <= S_WAIT;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_spectrum_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_spectrum_server
// Purpose  : Scoreboard bench for fft_spectrum_server. Two instances share the
//            stimulus (SHIFT=0 and SHIFT=4); a frame-level model predicts the
//            displayed spectrum and the status counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_spectrum_server;
    localparam int N = 256;

    logic               pix_clk = 1'b0;
    logic               rst;
    logic               fft_valid, fft_last, vs_in, data_req;
    logic signed [15:0] fft_re, fft_im;
    logic [9:0]         RAM_address;
    logic [31:0]        d0_data, d4_data;
    logic               d0_vld, d4_vld, d0_fr, d4_fr;
    logic [7:0]         d0_drop, d4_drop, d0_err, d4_err;

    always #5 pix_clk = ~pix_clk;

    fft_spectrum_server #(.FFT_POINT(N), .ADDR_BITS(10), .DATA_W(16), .SHIFT(0), .VS_POL(1)) dut0 (
        .pix_clk(pix_clk), .rst(rst), .fft_valid(fft_valid), .fft_last(fft_last),
        .fft_re(fft_re), .fft_im(fft_im), .vs_in(vs_in), .data_req(data_req),
        .RAM_address(RAM_address), .fft_data(d0_data), .fft_data_vld(d0_vld),
        .frame_ready(d0_fr), .drop_cnt(d0_drop), .err_cnt(d0_err));

    fft_spectrum_server #(.FFT_POINT(N), .ADDR_BITS(10), .DATA_W(16), .SHIFT(4), .VS_POL(1)) dut4 (
        .pix_clk(pix_clk), .rst(rst), .fft_valid(fft_valid), .fft_last(fft_last),
        .fft_re(fft_re), .fft_im(fft_im), .vs_in(vs_in), .data_req(data_req),
        .RAM_address(RAM_address), .fft_data(d4_data), .fft_data_vld(d4_vld),
        .frame_ready(d4_fr), .drop_cnt(d4_drop), .err_cnt(d4_err));

    typedef struct {
        longint unsigned val;
        int              cyc;
    } rd_t;

    int  n_checks = 0;
    int  n_errs   = 0;
    int  cyc      = 0;
    rd_t exp_q[$];
    bit  chk_hold = 1'b0;
    longint unsigned last_val = 0;

    // Frame-level reference: displayed spectrum, spectrum awaiting vsync
    longint unsigned m_disp[N];
    longint unsigned m_pend[N];
    bit m_ready, m_wait;
    int m_drop, m_err;

    always @(posedge pix_clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data
    always @(negedge pix_clk) begin
        rd_t e;
        if (rst) begin
            chk_hold = 1'b0;
        end else if (d0_vld) begin
            if (exp_q.size() == 0) begin
                chk("spurious_vld", longint'(d0_vld), 0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_latency", cyc, e.cyc);
                chk("rd_data_shift0", longint'(d0_data), longint'(e.val[31:0]));
                chk("rd_data_shift4", longint'(d4_data), longint'(e.val >> 4));
                chk("rd_vld_shift4", longint'(d4_vld), 1);
                last_val = e.val;
                chk_hold = 1'b1;
            end
        end else begin
            if (chk_hold) begin
                chk("rd_hold", longint'(d0_data), longint'(last_val[31:0]));
                chk_hold = 1'b0;
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("rd_missing_vld", longint'(d0_vld), 1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge pix_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fft_valid = 0; fft_last = 0; fft_re = 0; fft_im = 0;
        vs_in = 0; data_req = 0; RAM_address = 0;
        repeat (3) tick();
        chk("reset_data", longint'(d0_data), 0);
        chk("reset_vld", longint'(d0_vld), 0);
        chk("reset_frame_ready", longint'(d0_fr), 0);
        chk("reset_drop", longint'(d0_drop), 0);
        chk("reset_err", longint'(d4_err), 0);
        rst = 1'b0;
        m_ready = 0; m_wait = 0; m_drop = 0; m_err = 0;
        tick();
    endtask

    // kind: 0 random, 1 ramp re=k im=0, 2 constant (cre, cim)
    task automatic send_frame(input int n, input int last_at, input int kind,
                              input int cre, input int cim, input bit coincide);
        longint unsigned pw[N];
        for (int i = 0; i < n; i++) begin
            logic signed [15:0] re, im;
            if ($urandom_range(0, 3) == 0) begin
                fft_valid = 0; fft_last = 0;
                tick();
            end
            case (kind)
                0:       begin re = 16'($urandom); im = 16'($urandom); end
                1:       begin re = 16'(i);        im = 16'(0);        end
                default: begin re = 16'(cre);      im = 16'(cim);      end
            endcase
            fft_valid = 1; fft_last = (i == last_at); fft_re = re; fft_im = im;
            if (i < N) pw[i] = longint'(re) * longint'(re) + longint'(im) * longint'(im);
            tick();
        end
        fft_valid = 0; fft_last = 0;
        if (coincide) begin
            // vs edge lands on the same clock edge that completes the last write
            tick();
            vs_in = 1;
            repeat (3) tick();
            vs_in = 0;
            tick();
        end else begin
            repeat (3) tick();
        end
        if (m_wait) m_drop++;
        else if (n == N && last_at == N - 1) begin m_pend = pw; m_wait = 1; end
        else m_err++;
    endtask

    task automatic vs_pulse();
        vs_in = 1;
        repeat (3) tick();
        vs_in = 0;
        repeat (2) tick();
        if (m_wait) begin m_disp = m_pend; m_ready = 1; m_wait = 0; end
    endtask

    task automatic do_read(input int addr);
        rd_t e;
        data_req = 1; RAM_address = 10'(addr);
        e.val = (m_ready && addr < N) ? m_disp[addr] : 64'd0;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
        tick();
        data_req = 0;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_frame_ready0"}, longint'(d0_fr), longint'(m_ready));
        chk({tag, "_frame_ready4"}, longint'(d4_fr), longint'(m_ready));
        chk({tag, "_drop0"}, longint'(d0_drop), m_drop);
        chk({tag, "_drop4"}, longint'(d4_drop), m_drop);
        chk({tag, "_err0"}, longint'(d0_err), m_err);
        chk({tag, "_err4"}, longint'(d4_err), m_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        // No frame yet: reads return zero with a valid strobe
        do_read(5);
        tick();

        // Ramp frame: bin k holds k*k
        send_frame(N, N - 1, 1, 0, 0, 0);
        vs_pulse();
        do_read(3);
        do_read(255);
        tick();
        do_read(300);
        tick();
        check_counts("ramp");

        // A displayed, B pending, C dropped; next vsync shows B
        send_frame(N, N - 1, 2, 1, 0, 0);
        vs_pulse();
        send_frame(N, N - 1, 2, 2, 0, 0);
        send_frame(N, N - 1, 2, 3, 0, 0);
        do_read(10);
        tick();
        check_counts("drop");
        vs_pulse();
        do_read(10);
        do_read(0);
        tick();

        // Early fft_last: counted as error, vsync does not swap
        send_frame(101, 100, 0, 0, 0, 0);
        vs_pulse();
        do_read(20);
        tick();
        check_counts("early_last");
        send_frame(N, N - 1, 0, 0, 0, 0);
        vs_pulse();
        for (int i = 0; i < 4; i++) do_read($urandom_range(0, N - 1));
        tick();

        // Full-scale negative input; frame completes on the vs edge itself
        send_frame(N, N - 1, 2, -32768, -32768, 1);
        do_read(7);
        tick();
        check_counts("coincide");
        vs_pulse();
        do_read(7);
        do_read(N - 1);
        tick();

        // Randomised mix of good, early-last and missing-last frames
        for (int it = 0; it < 8; it++) begin
            int r;
            r = $urandom_range(0, 4);
            if (r == 2) begin
                int la;
                la = $urandom_range(0, N - 2);
                send_frame(la + 1, la, 0, 0, 0, 0);
            end else if (r == 4) begin
                send_frame(N + 5, N + 4, 0, 0, 0, 0);
            end else begin
                send_frame(N, N - 1, 0, 0, 0, 0);
            end
            if ($urandom_range(0, 2) != 0) vs_pulse();
            for (int j = 0; j < 3; j++) do_read($urandom_range(0, 299));
            tick();
            check_counts("random");
        end

        // Reset mid-frame: partial frame abandoned, reads return zero
        for (int i = 0; i < 50; i++) begin
            fft_valid = 1; fft_last = 0;
            fft_re = 16'($urandom); fft_im = 16'($urandom);
            tick();
        end
        do_reset();
        do_read(3);
        tick();
        check_counts("post_reset");
        send_frame(N, N - 1, 0, 0, 0, 0);
        vs_pulse();
        for (int i = 0; i < 3; i++) do_read($urandom_range(0, N - 1));
        tick();
        check_counts("final");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
